// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: streaming program load port plus 1-cycle registered fetch port.
// Optional IMEM_PARITY_EN adds a stored even-parity bit per word and a PARITY_ERR output.
//
// state   | meaning
// ST_RUN  | fetches serviced, LOAD_START accepted
// ST_LOAD | program words accepted on LOAD_VALID, fetches dropped
module instr_mem_loadable #(
  parameter int               WIDTH     = 32,
  parameter int               MEM_DEPTH = 256,
  parameter logic [WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013)
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         FETCH_REQ,
  input  logic [WIDTH-1:0]             ADDRESS,
  output logic [WIDTH-1:0]             INSTRUCTION,
  output logic                         INSTR_VALID,
  output logic                         MISALIGNED,
  input  logic                         LOAD_START,
  input  logic [$clog2(MEM_DEPTH):0]   LOAD_LEN,
  input  logic                         LOAD_VALID,
  input  logic [WIDTH-1:0]             LOAD_DATA,
  output logic                         LOAD_READY,
  output logic                         LOAD_DONE,
`ifdef IMEM_PARITY_EN
  output logic                         PARITY_ERR,
`endif
  output logic                         BUSY
);

  localparam int AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LEN_W = $clog2(MEM_DEPTH) + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(MEM_DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  typedef enum logic {ST_RUN, ST_LOAD} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   wptr_q, wptr_d;
  logic [LEN_W-1:0]   loaded_len_q, loaded_len_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   instruction_q, instruction_d;
  logic               instr_valid_q, instr_valid_d;
  logic               misaligned_q, misaligned_d;
  logic               load_done_q, load_done_d;
  logic               busy_q, busy_d;
  logic               parity_err_q, parity_err_d;

  logic [MW-1:0]      mem [MEM_DEPTH];
  logic [MW-1:0]      wr_word;
  logic [MW-1:0]      rd_word;
  logic               mem_we;
  logic [WIDTH-1:0]   idx;
  logic               below;
  logic               hit;

  generate
    if (BASE_ADDR == '0) begin : g_base_zero
      assign below = 1'b0;
    end else begin : g_base_nonzero
      assign below = ADDRESS < BASE_ADDR;
    end
  endgenerate

  assign idx     = (ADDRESS - BASE_ADDR) >> 2;
  assign hit     = !below && (idx < WIDTH'(loaded_len_q)) && (idx < WIDTH'(MEM_DEPTH));
  assign rd_word = mem[idx[AW-1:0]];
`ifdef IMEM_PARITY_EN
  assign wr_word = {^LOAD_DATA, LOAD_DATA};
`else
  assign wr_word = LOAD_DATA;
`endif

  // Array is deliberately not reset; loaded_len gates every read instead.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[wptr_q[AW-1:0]] <= wr_word;
    end
  end

  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    loaded_len_d  = loaded_len_q;
    rem_d         = rem_q;
    instruction_d = instruction_q;
    instr_valid_d = 1'b0;
    misaligned_d  = 1'b0;
    load_done_d   = 1'b0;
    parity_err_d  = 1'b0;
    mem_we        = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (LOAD_START) begin
          wptr_d       = '0;
          loaded_len_d = '0;
          if (LOAD_LEN == '0) begin
            load_done_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
            rem_d   = (LOAD_LEN > DEPTH_L) ? DEPTH_L : LOAD_LEN;
          end
        end else if (FETCH_REQ) begin
          instr_valid_d = 1'b1;
          if (ADDRESS[1:0] != 2'b00) begin
            instruction_d = NOP_INSTR;
            misaligned_d  = 1'b1;
          end else if (!hit) begin
            instruction_d = NOP_INSTR;
          end else begin
            instruction_d = rd_word[WIDTH-1:0];
`ifdef IMEM_PARITY_EN
            if (^rd_word) begin
              instruction_d = NOP_INSTR;
              parity_err_d  = 1'b1;
            end
`endif
          end
        end
      end
      ST_LOAD: begin
        if (LOAD_VALID) begin
          mem_we       = RST_N;
          wptr_d       = wptr_q + LEN_W'(1);
          loaded_len_d = wptr_q + LEN_W'(1);
          rem_d        = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d     = ST_RUN;
            load_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
    busy_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= ST_RUN;
      wptr_q        <= '0;
      loaded_len_q  <= '0;
      rem_q         <= '0;
      instruction_q <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      load_done_q   <= 1'b0;
      busy_q        <= 1'b0;
      parity_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      loaded_len_q  <= loaded_len_d;
      rem_q         <= rem_d;
      instruction_q <= instruction_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
      load_done_q   <= load_done_d;
      busy_q        <= busy_d;
      parity_err_q  <= parity_err_d;
    end
  end

  assign INSTRUCTION = instruction_q;
  assign INSTR_VALID = instr_valid_q;
  assign MISALIGNED  = misaligned_q;
  assign LOAD_READY  = busy_q;
  assign BUSY        = busy_q;
  assign LOAD_DONE   = load_done_q;
`ifdef IMEM_PARITY_EN
  assign PARITY_ERR  = parity_err_q;
`else
  logic unused_parity;
  assign unused_parity = parity_err_q;
`endif

endmodule
